// File: rtl/addsub_pkg.sv
// ============================================================================
// Module : addsub_pkg
// Brief  : Shared types and helpers for the sequential add/subtract unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int slice_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_seq_add_slice.sv
// ============================================================================
// Module : add_slice
// Brief  : CHUNK-bit ripple of full-adder cells; also exposes the carry into
//          the top bit so the caller can form signed overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module add_slice #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/addsub_seq.sv
// ============================================================================
// Module : addsub_seq
// Brief  : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB first.
//          Optional saturation enabled by macro ADDSUB_SAT_EN (adds port sat).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   x,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int SW     = slice_w(NSLICE);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] C_SAT_MIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] C_SAT_MAX = ~C_SAT_MIN;
    logic                        r_sat;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [SW-1:0]      r_slice;
    logic [WIDTH:0]     r_x;
    logic               r_ovf;

    int                 w_base;
    logic               w_last;
    logic [CHUNK-1:0]   w_sa;
    logic [CHUNK-1:0]   w_sb;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_c_msb;
    logic               w_ovf;

    assign w_base = int'(r_slice) * CHUNK;
    assign w_last = (r_slice == SW'(NSLICE - 1));
    assign w_sa   = r_a[w_base +: CHUNK];
    assign w_sb   = r_b[w_base +: CHUNK];
    assign w_ovf  = w_c_msb ^ w_cout;

    add_slice #(.CHUNK(CHUNK)) u_slice (
        .i_a     (w_sa),
        .i_b     (w_sb),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_slice <= '0;
            r_x     <= '0;
            r_ovf   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    // Subtraction runs as A + ~B + 1: invert B here, seed the carry.
                    r_a     <= a;
                    r_b     <= b ^ {WIDTH{sub}};
                    r_sub   <= sub;
                    r_carry <= sub;
                    r_slice <= '0;
`ifdef ADDSUB_SAT_EN
                    r_sat   <= sat;
`endif
                end
                RUN: begin
                    r_x[w_base +: CHUNK] <= w_sum;
                    r_carry              <= w_cout;
                    r_slice              <= r_slice + SW'(1);
                    if (w_last) begin
                        r_x[WIDTH] <= w_cout ^ r_sub;
                        r_ovf      <= w_ovf;
`ifdef ADDSUB_SAT_EN
                        // A wrapped sign of 1 means the true result was positive.
                        if (r_sat && w_ovf) begin
                            r_x[WIDTH-1:0] <= w_sum[CHUNK-1] ? C_SAT_MAX : C_SAT_MIN;
                            r_x[WIDTH]     <= ~w_sum[CHUNK-1];
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign x         = r_x;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
